// File: rtl/alu_reservation_station_pkg.sv
// Shared widths, op codes and entry types for the ALU reservation station.
// Wakeup helper used by both allocation bypass and per-entry snooping.
package alu_reservation_station_pkg;

    localparam int RS_SIZE       = 8;
    localparam int RS_INDEX_BIT  = 3;
    localparam int ROB_INDEX_BIT = 4;
    localparam int TYPE_BIT      = 5;

    localparam logic [TYPE_BIT-1:0] OP_ADD  = 5'd0;
    localparam logic [TYPE_BIT-1:0] OP_SUB  = 5'd1;
    localparam logic [TYPE_BIT-1:0] OP_XOR  = 5'd2;
    localparam logic [TYPE_BIT-1:0] OP_OR   = 5'd3;
    localparam logic [TYPE_BIT-1:0] OP_AND  = 5'd4;
    localparam logic [TYPE_BIT-1:0] OP_SLL  = 5'd5;
    localparam logic [TYPE_BIT-1:0] OP_SRL  = 5'd6;
    localparam logic [TYPE_BIT-1:0] OP_SRA  = 5'd7;
    localparam logic [TYPE_BIT-1:0] OP_SLT  = 5'd8;
    localparam logic [TYPE_BIT-1:0] OP_SLTU = 5'd9;
    localparam logic [TYPE_BIT-1:0] OP_BEQ  = 5'd10;
    localparam logic [TYPE_BIT-1:0] OP_BNE  = 5'd11;
    localparam logic [TYPE_BIT-1:0] OP_BLT  = 5'd12;
    localparam logic [TYPE_BIT-1:0] OP_BGE  = 5'd13;
    localparam logic [TYPE_BIT-1:0] OP_BLTU = 5'd14;
    localparam logic [TYPE_BIT-1:0] OP_BGEU = 5'd15;
    localparam logic [TYPE_BIT-1:0] OP_JALR = 5'd16;

    typedef struct packed {
        logic [TYPE_BIT-1:0]      op;
        logic [31:0]              vj;
        logic [31:0]              vk;
        logic                     has_qj;
        logic                     has_qk;
        logic [ROB_INDEX_BIT-1:0] qj;
        logic [ROB_INDEX_BIT-1:0] qk;
        logic [ROB_INDEX_BIT-1:0] rob_id;
    } rs_entry_t;

    typedef struct packed {
        logic                     rdy;
        logic [ROB_INDEX_BIT-1:0] id;
        logic [31:0]              val;
    } cdb_t;

    typedef struct packed {
        logic        pend;
        logic [31:0] val;
    } opnd_t;

    // Resolve one operand against both broadcasts; ALU wins on a tie.
    function automatic opnd_t snoop(
        input logic                     pend,
        input logic [ROB_INDEX_BIT-1:0] q,
        input logic [31:0]              v,
        input cdb_t                     a,
        input cdb_t                     l
    );
        opnd_t r;
        r.pend = pend;
        r.val  = v;
        if (pend && a.rdy && q == a.id) begin
            r.pend = 1'b0;
            r.val  = a.val;
        end else if (pend && l.rdy && q == l.id) begin
            r.pend = 1'b0;
            r.val  = l.val;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_reservation_station_rs_find_first.sv
// Find-first-set over a bit vector: lowest set index plus a found flag.
// Used for free-slot allocation and issue selection.
module rs_find_first #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         found
);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_reservation_station.sv
// ALU reservation station: allocate, CDB wakeup, single-issue select.
// Define RS_AGE_ORDER_EN to issue oldest-ready instead of lowest-index.
module alu_reservation_station
    import alu_reservation_station_pkg::*;
(
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     clear_in,
    input  logic                     issue_valid,
    input  logic [TYPE_BIT-1:0]      issue_type,
    input  logic [31:0]              issue_vj,
    input  logic [31:0]              issue_vk,
    input  logic                     issue_has_qj,
    input  logic                     issue_has_qk,
    input  logic [ROB_INDEX_BIT-1:0] issue_qj,
    input  logic [ROB_INDEX_BIT-1:0] issue_qk,
    input  logic [ROB_INDEX_BIT-1:0] issue_rob_id,
    output logic                     full_out,
    input  logic                     cdb_alu_ready,
    input  logic [ROB_INDEX_BIT-1:0] cdb_alu_rob_id,
    input  logic [31:0]              cdb_alu_value,
    input  logic                     cdb_lsb_ready,
    input  logic [ROB_INDEX_BIT-1:0] cdb_lsb_rob_id,
    input  logic [31:0]              cdb_lsb_value,
    output logic                     alu_req,
    output logic [TYPE_BIT-1:0]      alu_type,
    output logic [31:0]              alu_r1,
    output logic [31:0]              alu_r2,
    output logic [ROB_INDEX_BIT-1:0] alu_rob_id
);

    rs_entry_t                ent  [RS_SIZE];
    rs_entry_t                woke [RS_SIZE];
    rs_entry_t                new_ent;
    logic [RS_SIZE-1:0]       valid_q;
    logic [RS_SIZE-1:0]       ready_vec;
    logic [RS_SIZE-1:0]       pick_vec;
    logic [RS_INDEX_BIT-1:0]  free_idx;
    logic [RS_INDEX_BIT-1:0]  sel_idx;
    logic                     free_found;
    logic                     sel_found;
    logic                     alloc_en;
    cdb_t                     alu_bc;
    cdb_t                     lsb_bc;

    assign alu_bc   = '{cdb_alu_ready, cdb_alu_rob_id, cdb_alu_value};
    assign lsb_bc   = '{cdb_lsb_ready, cdb_lsb_rob_id, cdb_lsb_value};
    assign full_out = &valid_q;
    assign alloc_en = issue_valid & free_found;

    rs_find_first #(.N(RS_SIZE), .W(RS_INDEX_BIT)) u_free (
        .vec   (~valid_q),
        .idx   (free_idx),
        .found (free_found)
    );

    rs_find_first #(.N(RS_SIZE), .W(RS_INDEX_BIT)) u_sel (
        .vec   (pick_vec),
        .idx   (sel_idx),
        .found (sel_found)
    );

    // Readiness from registered state only; no wakeup-to-issue bypass.
    always_comb begin
        ready_vec = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            ready_vec[i] = valid_q[i] & ~ent[i].has_qj & ~ent[i].has_qk;
        end
    end

    // Per-entry operand snooping on both broadcast ports.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            woke[i] = ent[i];
            {woke[i].has_qj, woke[i].vj} =
                snoop(ent[i].has_qj, ent[i].qj, ent[i].vj, alu_bc, lsb_bc);
            {woke[i].has_qk, woke[i].vk} =
                snoop(ent[i].has_qk, ent[i].qk, ent[i].vk, alu_bc, lsb_bc);
        end
    end

    // Incoming entry, with same-edge broadcast capture.
    always_comb begin
        new_ent        = '0;
        new_ent.op     = issue_type;
        new_ent.qj     = issue_qj;
        new_ent.qk     = issue_qk;
        new_ent.rob_id = issue_rob_id;
        {new_ent.has_qj, new_ent.vj} =
            snoop(issue_has_qj, issue_qj, issue_vj, alu_bc, lsb_bc);
        {new_ent.has_qk, new_ent.vk} =
            snoop(issue_has_qk, issue_qk, issue_vk, alu_bc, lsb_bc);
    end

`ifdef RS_AGE_ORDER_EN
    // older_q[j][i] set means entry j was allocated before entry i.
    logic [RS_SIZE-1:0] older_q [RS_SIZE];

    // Keep only ready entries with no older ready entry.
    always_comb begin
        pick_vec = ready_vec;
        for (int i = 0; i < RS_SIZE; i++) begin
            for (int j = 0; j < RS_SIZE; j++) begin
                if (ready_vec[j] && older_q[j][i]) pick_vec[i] = 1'b0;
            end
        end
    end

    // New entry is younger than every live entry and older than none.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) older_q[i] <= '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                for (int i = 0; i < RS_SIZE; i++) older_q[i] <= '0;
            end else if (alloc_en) begin
                for (int j = 0; j < RS_SIZE; j++) begin
                    older_q[j][free_idx] <= valid_q[j];
                end
                older_q[free_idx] <= '0;
            end
        end
    end
`else
    assign pick_vec = ready_vec;
`endif

    // Entry storage, issue register and valid bits.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            valid_q    <= '0;
            alu_req    <= 1'b0;
            alu_type   <= '0;
            alu_r1     <= '0;
            alu_r2     <= '0;
            alu_rob_id <= '0;
            for (int i = 0; i < RS_SIZE; i++) ent[i] <= '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                valid_q <= '0;
                alu_req <= 1'b0;
            end else begin
                for (int i = 0; i < RS_SIZE; i++) ent[i] <= woke[i];
                alu_req <= sel_found;
                if (sel_found) begin
                    alu_type         <= ent[sel_idx].op;
                    alu_r1           <= ent[sel_idx].vj;
                    alu_r2           <= ent[sel_idx].vk;
                    alu_rob_id       <= ent[sel_idx].rob_id;
                    valid_q[sel_idx] <= 1'b0;
                end
                if (alloc_en) begin
                    ent[free_idx]     <= new_ent;
                    valid_q[free_idx] <= 1'b1;
                end
            end
        end
    end

    // Dispatcher must never allocate into a full station.
    a_no_alloc_when_full: assert property (
        @(posedge clk_in) disable iff (rst_in)
        !(rdy_in && !clear_in && issue_valid && full_out)
    );

endmodule

// File: tb/tb_alu_reservation_station.sv
// Directed scoreboard bench for alu_reservation_station.
// Monitor pops expected issues whenever alu_req is seen.
module tb_alu_reservation_station;
    import alu_reservation_station_pkg::*;

    logic                     clk_in = 1'b0;
    logic                     rst_in;
    logic                     rdy_in;
    logic                     clear_in;
    logic                     issue_valid;
    logic [TYPE_BIT-1:0]      issue_type;
    logic [31:0]              issue_vj;
    logic [31:0]              issue_vk;
    logic                     issue_has_qj;
    logic                     issue_has_qk;
    logic [ROB_INDEX_BIT-1:0] issue_qj;
    logic [ROB_INDEX_BIT-1:0] issue_qk;
    logic [ROB_INDEX_BIT-1:0] issue_rob_id;
    logic                     full_out;
    logic                     cdb_alu_ready;
    logic [ROB_INDEX_BIT-1:0] cdb_alu_rob_id;
    logic [31:0]              cdb_alu_value;
    logic                     cdb_lsb_ready;
    logic [ROB_INDEX_BIT-1:0] cdb_lsb_rob_id;
    logic [31:0]              cdb_lsb_value;
    logic                     alu_req;
    logic [TYPE_BIT-1:0]      alu_type;
    logic [31:0]              alu_r1;
    logic [31:0]              alu_r2;
    logic [ROB_INDEX_BIT-1:0] alu_rob_id;

    typedef struct packed {
        logic [TYPE_BIT-1:0]      t;
        logic [31:0]              r1;
        logic [31:0]              r2;
        logic [ROB_INDEX_BIT-1:0] rob;
    } exp_t;

    exp_t sb [$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    alu_reservation_station dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .clear_in       (clear_in),
        .issue_valid    (issue_valid),
        .issue_type     (issue_type),
        .issue_vj       (issue_vj),
        .issue_vk       (issue_vk),
        .issue_has_qj   (issue_has_qj),
        .issue_has_qk   (issue_has_qk),
        .issue_qj       (issue_qj),
        .issue_qk       (issue_qk),
        .issue_rob_id   (issue_rob_id),
        .full_out       (full_out),
        .cdb_alu_ready  (cdb_alu_ready),
        .cdb_alu_rob_id (cdb_alu_rob_id),
        .cdb_alu_value  (cdb_alu_value),
        .cdb_lsb_ready  (cdb_lsb_ready),
        .cdb_lsb_rob_id (cdb_lsb_rob_id),
        .cdb_lsb_value  (cdb_lsb_value),
        .alu_req        (alu_req),
        .alu_type       (alu_type),
        .alu_r1         (alu_r1),
        .alu_r2         (alu_r2),
        .alu_rob_id     (alu_rob_id)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_in);
    endtask

    task automatic alloc(input logic [TYPE_BIT-1:0] t,
                         input logic [31:0] vj, input logic [31:0] vk,
                         input logic hj, input logic [ROB_INDEX_BIT-1:0] qj,
                         input logic hk, input logic [ROB_INDEX_BIT-1:0] qk,
                         input logic [ROB_INDEX_BIT-1:0] rob);
        issue_valid  = 1'b1;
        issue_type   = t;
        issue_vj     = vj;
        issue_vk     = vk;
        issue_has_qj = hj;
        issue_qj     = qj;
        issue_has_qk = hk;
        issue_qk     = qk;
        issue_rob_id = rob;
    endtask

    task automatic quiet();
        issue_valid   = 1'b0;
        cdb_alu_ready = 1'b0;
        cdb_lsb_ready = 1'b0;
        clear_in      = 1'b0;
    endtask

    // Scoreboard monitor: every observed issue must match the queue head.
    always @(negedge clk_in) begin
        if (!rst_in && alu_req === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_issue: got rob %0d expected none",
                         alu_rob_id);
            end else begin
                mon_e = sb.pop_front();
                chk("issue_type", 32'(alu_type), 32'(mon_e.t));
                chk("issue_r1", alu_r1, mon_e.r1);
                chk("issue_r2", alu_r2, mon_e.r2);
                chk("issue_rob", 32'(alu_rob_id), 32'(mon_e.rob));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_in = 1'b1;
        rdy_in = 1'b1;
        quiet();
        issue_type = '0; issue_vj = '0; issue_vk = '0;
        issue_has_qj = 1'b0; issue_has_qk = 1'b0;
        issue_qj = '0; issue_qk = '0; issue_rob_id = '0;
        cdb_alu_rob_id = '0; cdb_alu_value = '0;
        cdb_lsb_rob_id = '0; cdb_lsb_value = '0;
        repeat (2) @(posedge clk_in);
        sample();
        chk("rst_req", 32'(alu_req), 0);
        chk("rst_type", 32'(alu_type), 0);
        chk("rst_r1", alu_r1, 0);
        chk("rst_r2", alu_r2, 0);
        chk("rst_rob", 32'(alu_rob_id), 0);
        chk("rst_full", 32'(full_out), 0);
        rst_in = 1'b0;
        step();

        // Ready op: issues one edge after allocation.
        alloc(OP_ADD, 5, 7, 0, 0, 0, 0, 3);
        sb.push_back('{OP_ADD, 32'd5, 32'd7, 4'd3});
        step(); quiet();
        sample(); chk("t1_req_e0", 32'(alu_req), 0);
        step(); sample(); chk("t1_req_e1", 32'(alu_req), 1);
        step(); sample(); chk("t1_req_e2", 32'(alu_req), 0);

        // Pending rs1 woken by ALU broadcast three edges later.
        step();
        alloc(OP_SUB, 0, 1, 1, 2, 0, 0, 4);
        sb.push_back('{OP_SUB, 32'h10, 32'd1, 4'd4});
        step(); quiet();
        step();
        step();
        cdb_alu_ready = 1'b1; cdb_alu_rob_id = 2; cdb_alu_value = 32'h10;
        step(); quiet();
        sample(); chk("t2_req_wake", 32'(alu_req), 0);
        step(); sample(); chk("t2_req_issue", 32'(alu_req), 1);

        // Same-edge LSB bypass into a new entry.
        step();
        alloc(OP_AND, 3, 0, 0, 0, 1, 6, 5);
        cdb_lsb_ready = 1'b1; cdb_lsb_rob_id = 6; cdb_lsb_value = 32'hAB;
        sb.push_back('{OP_AND, 32'd3, 32'hAB, 4'd5});
        step(); quiet();
        sample(); chk("t3_req_alloc", 32'(alu_req), 0);
        step(); sample(); chk("t3_req_issue", 32'(alu_req), 1);

        // Fill all entries pending on tags 8..15, then wake entry 4.
        step();
        for (int i = 0; i < RS_SIZE; i++) begin
            alloc(OP_ADD, 0, 32'(i), 1, 4'(8 + i), 0, 0, 4'(i));
            step();
        end
        quiet();
        sample();
        chk("t4_full", 32'(full_out), 1);
        chk("t4_req_idle", 32'(alu_req), 0);
        step(); sample(); chk("t4_req_idle2", 32'(alu_req), 0);
        cdb_alu_ready = 1'b1; cdb_alu_rob_id = 12; cdb_alu_value = 32'h44;
        sb.push_back('{OP_ADD, 32'h44, 32'd4, 4'd4});
        step(); quiet();
        sample();
        chk("t4_full_wake", 32'(full_out), 1);
        chk("t4_req_wake", 32'(alu_req), 0);
        step(); sample();
        chk("t4_req_issue", 32'(alu_req), 1);
        chk("t4_full_after", 32'(full_out), 0);

        // Flush with a same-edge allocation; nothing may issue afterwards.
        step();
        clear_in = 1'b1;
        alloc(OP_ADD, 1, 1, 0, 0, 0, 0, 9);
        step(); quiet();
        sample();
        chk("t5_full", 32'(full_out), 0);
        chk("t5_req", 32'(alu_req), 0);
        for (int i = 0; i < RS_SIZE; i++) begin
            step();
            cdb_alu_ready = 1'b1;
            cdb_alu_rob_id = 4'(8 + i);
            cdb_alu_value = 32'(i);
        end
        step(); quiet();
        repeat (2) step();
        sample(); chk("t5_still_empty", 32'(full_out), 0);

        // Stall: rdy_in low holds the pending issue back.
        step();
        alloc(OP_OR, 32'hF0, 32'h0F, 0, 0, 0, 0, 6);
        sb.push_back('{OP_OR, 32'hF0, 32'h0F, 4'd6});
        step(); quiet();
        rdy_in = 1'b0;
        sample(); chk("t6_stall0", 32'(alu_req), 0);
        step(); sample(); chk("t6_stall1", 32'(alu_req), 0);
        step(); sample(); chk("t6_stall2", 32'(alu_req), 0);
        rdy_in = 1'b1;
        step(); sample(); chk("t6_resume", 32'(alu_req), 1);

        // Ordering: A in slot 0, B in slot 1, C reuses slot 0.
        step();
        alloc(OP_SUB, 0, 32'h11, 1, 7, 0, 0, 1);
        step();
        alloc(OP_XOR, 0, 32'h22, 1, 8, 0, 0, 2);
        step(); quiet();
        cdb_alu_ready = 1'b1; cdb_alu_rob_id = 7; cdb_alu_value = 32'hA;
        sb.push_back('{OP_SUB, 32'hA, 32'h11, 4'd1});
        step(); quiet();
        step();
        alloc(OP_ADD, 32'hC, 32'hD, 0, 0, 0, 0, 3);
        cdb_lsb_ready = 1'b1; cdb_lsb_rob_id = 8; cdb_lsb_value = 32'hB;
`ifdef RS_AGE_ORDER_EN
        sb.push_back('{OP_XOR, 32'hB, 32'h22, 4'd2});
        sb.push_back('{OP_ADD, 32'hC, 32'hD, 4'd3});
`else
        sb.push_back('{OP_ADD, 32'hC, 32'hD, 4'd3});
        sb.push_back('{OP_XOR, 32'hB, 32'h22, 4'd2});
`endif
        step(); quiet();
        repeat (4) step();
        sample();
        chk("sb_drained", 32'(sb.size()), 0);
        chk("end_full", 32'(full_out), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
